// File: rtl/secded_scrub_ctrl.sv
// SEC-DED (13,8) memory port owner: encodes host writes, corrects host reads and runs a
// background scrubber that writes back single-error corrections and logs uncorrectable words.
module secded_scrub_ctrl #(
  parameter int ADDR_W         = 4,
  parameter int DEPTH          = 16,
  parameter int SCRUB_INTERVAL = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scrub_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  output logic              host_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [12:0]       mem_wdata,
  input  logic [12:0]       mem_rdata,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int TMR_W = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_RD,
    S_SCRUB_RD,
    S_SCRUB_CHK,
    S_SCRUB_WB
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_scrub_ptr;
  logic [ADDR_W-1:0]   r_host_addr;
  logic [TMR_W-1:0]    r_timer;
  logic [12:0]         r_scrub_cw;
  logic [7:0]          r_wb_data;

  logic                w_scrub_due;
  logic [12:0]         w_dec_in;
  logic [3:0]          w_syn;
  logic                w_ov;
  logic [12:0]         w_cw_fix;
  logic [7:0]          w_data;
  logic                w_clean;
  logic                w_uncorr;
  logic [ADDR_W-1:0]   w_ptr_next;

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] cw;
    cw     = '0;
    cw[3]  = d[0];
    cw[5]  = d[1];
    cw[6]  = d[2];
    cw[7]  = d[3];
    cw[9]  = d[4];
    cw[10] = d[5];
    cw[11] = d[6];
    cw[12] = d[7];
    cw[1]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    cw[2]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    cw[4]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    cw[8]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    cw[0]  = ^cw[12:1];
    return cw;
  endfunction

  function automatic logic [3:0] syndrome(input logic [12:0] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i <= 12; i++) begin
      if (cw[i]) s = s ^ 4'(i);
    end
    return s;
  endfunction

  // One decoder serves both paths: host reads decode the live memory output, scrub checks
  // decode the codeword captured in SCRUB_RD.
  assign w_dec_in    = (r_state == S_SCRUB_CHK) ? r_scrub_cw : mem_rdata;
  assign w_syn       = syndrome(w_dec_in);
  assign w_ov        = ^w_dec_in;
  assign w_clean     = !w_ov && (w_syn == 4'd0);
  assign w_uncorr    = (w_ov && (w_syn > 4'd12)) || (!w_ov && (w_syn != 4'd0));
  assign w_cw_fix    = (w_ov && (w_syn != 4'd0) && (w_syn <= 4'd12)) ?
                       (w_dec_in ^ (13'd1 << w_syn)) : w_dec_in;
  assign w_data      = {w_cw_fix[12], w_cw_fix[11], w_cw_fix[10], w_cw_fix[9],
                        w_cw_fix[7],  w_cw_fix[6],  w_cw_fix[5],  w_cw_fix[3]};
  assign w_scrub_due = scrub_en && (r_timer == '0);
  assign w_ptr_next  = (r_scrub_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_scrub_ptr + ADDR_W'(1);

  // Memory strobes are gated by rst_n so nothing reaches the array while reset is held.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    host_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (host_req) begin
            host_gnt = 1'b1;
            mem_en   = 1'b1;
            mem_addr = host_addr;
            if (host_we) begin
              mem_we    = 1'b1;
              mem_wdata = encode(host_wdata);
            end
          end else if (w_scrub_due) begin
            mem_en   = 1'b1;
            mem_addr = r_scrub_ptr;
          end
        end
        S_SCRUB_WB: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = r_scrub_ptr;
          mem_wdata = encode(r_wb_data);
        end
        default: ;
      endcase
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_scrub_ptr <= '0;
      r_host_addr <= '0;
      r_timer     <= TMR_RELOAD;
      r_scrub_cw  <= '0;
      r_wb_data   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      host_err    <= 1'b0;
      corr_cnt    <= '0;
      uncorr_cnt  <= '0;
      err_addr    <= '0;
    end else begin
      host_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (host_req && !host_we) begin
            r_host_addr <= host_addr;
            r_state     <= S_HOST_RD;
          end
          // Host wins a tie; the timer stays at zero so the scrub remains pending.
          if (!host_req && w_scrub_due) begin
            r_timer <= TMR_RELOAD;
            r_state <= S_SCRUB_RD;
          end else if (scrub_en && (r_timer != '0)) begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_HOST_RD: begin
          host_rvalid <= 1'b1;
          host_rdata  <= w_data;
          host_err    <= w_uncorr;
          if (w_uncorr) begin
            err_addr <= r_host_addr;
            if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
          end
          r_state <= S_IDLE;
        end
        S_SCRUB_RD: begin
          r_scrub_cw <= mem_rdata;
          r_state    <= S_SCRUB_CHK;
        end
        S_SCRUB_CHK: begin
          if (w_clean) begin
            r_scrub_ptr <= w_ptr_next;
            r_state     <= S_IDLE;
          end else if (w_uncorr) begin
            err_addr    <= r_scrub_ptr;
            if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            r_scrub_ptr <= w_ptr_next;
            r_state     <= S_IDLE;
          end else begin
            r_wb_data <= w_data;
            if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
            r_state   <= S_SCRUB_WB;
          end
        end
        S_SCRUB_WB: begin
          r_scrub_ptr <= w_ptr_next;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Scoreboard bench for secded_scrub_ctrl: expected memory writes and host read results are
// queued as stimulus is driven and retired by monitors when the DUT produces them.
module tb_secded_scrub_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       chk_data;
  } rd_exp_t;

  logic        clk;
  logic        rst_n;
  logic        scrub_en;
  logic        host_req;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [7:0]  host_rdata;
  logic        host_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [12:0] mem_wdata;
  logic [12:0] mem_rdata;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  logic [3:0]  err_addr;

  logic        scrub_en_b;
  logic        host_gnt_b;
  logic        host_rvalid_b;
  logic [7:0]  host_rdata_b;
  logic        host_err_b;
  logic        mem_en_b;
  logic        mem_we_b;
  logic [1:0]  mem_addr_b;
  logic [12:0] mem_wdata_b;
  logic [12:0] mem_rdata_b;
  logic [1:0]  corr_cnt_b;
  logic [1:0]  uncorr_cnt_b;
  logic [1:0]  err_addr_b;

  logic [12:0] mem_a [16];
  logic [12:0] mem_b [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [16:0] wr_q[$];
  rd_exp_t     rd_q[$];
  int          gnt_q[$];

  secded_scrub_ctrl dut (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .err_addr(err_addr)
  );

  secded_scrub_ctrl #(.ADDR_W(2), .DEPTH(4), .SCRUB_INTERVAL(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .scrub_en(scrub_en_b),
    .host_req(1'b0), .host_we(1'b0), .host_addr(2'd0), .host_wdata(8'd0),
    .host_gnt(host_gnt_b), .host_rvalid(host_rvalid_b), .host_rdata(host_rdata_b),
    .host_err(host_err_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .corr_cnt(corr_cnt_b),
    .uncorr_cnt(uncorr_cnt_b), .err_addr(err_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) mem_a[mem_addr] <= mem_wdata;
    if (mem_en === 1'b1 && mem_we === 1'b0) mem_rdata <= mem_a[mem_addr];
    if (mem_en_b === 1'b1 && mem_we_b === 1'b1) mem_b[mem_addr_b] <= mem_wdata_b;
    if (mem_en_b === 1'b1 && mem_we_b === 1'b0) mem_rdata_b <= mem_b[mem_addr_b];
  end

  // Reference encoder built from the generic Hamming rule: data fills non-power-of-two positions,
  // parity bit 2^k covers every position whose index has bit k set.
  function automatic logic [12:0] ref_encode(input logic [7:0] d);
    logic [12:0] cw;
    logic        x;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      x = 1'b0;
      for (int p = 1; p <= 12; p++) begin
        if (((p & (p - 1)) != 0) && p[b]) x = x ^ cw[p];
      end
      cw[1 << b] = x;
    end
    cw[0] = ^cw[12:1];
    return cw;
  endfunction

  // Write monitor: every memory write of the main DUT must match the head of wr_q.
  always @(negedge clk) begin
    logic [16:0] exp_w;
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write unexpected: addr=%0d wdata=%h", mem_addr, mem_wdata);
      end else begin
        exp_w = wr_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL mem_write: got addr=%0d wdata=%h, expected addr=%0d wdata=%h",
                   mem_addr, mem_wdata, exp_w[16:13], exp_w[12:0]);
        end
      end
    end
  end

  // Read monitor: every rvalid must match the head of rd_q and arrive two cycles after grant.
  always @(negedge clk) begin
    rd_exp_t e;
    int      c;
    if (host_rvalid === 1'b1) begin
      checks++;
      if (rd_q.size() == 0 || gnt_q.size() == 0) begin
        errors++;
        $display("FAIL host_rvalid unexpected: rdata=%h err=%b", host_rdata, host_err);
      end else begin
        e = rd_q.pop_front();
        c = gnt_q.pop_front();
        if (host_err !== e.err || (e.chk_data && host_rdata !== e.data) || cyc != c) begin
          errors++;
          $display("FAIL host_read: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                   host_rdata, host_err, cyc, e.data, e.err, c);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int gcyc);
    bit got;
    got  = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (host_gnt === 1'b1) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL host_gnt timeout: got none in 10 cycles, expected a grant");
    end
    @(posedge clk);
    #1;
    host_req = 1'b0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    int g;
    wr_q.push_back({a, ref_encode(d)});
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    wait_gnt(g);
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] d, input logic err,
                           input logic chk_data);
    int g;
    rd_q.push_back('{data: d, err: err, chk_data: chk_data});
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    wait_gnt(g);
    gnt_q.push_back(g + 2);
  endtask

  task automatic find_scrub_read(input logic [3:0] exp_addr, output int t);
    bit got;
    got = 1'b0;
    t   = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1 && mem_we === 1'b0 && host_gnt === 1'b0) begin
        got = 1'b1;
        t   = cyc;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL scrub_read timeout: got none in 300 cycles, expected read @%0d", exp_addr);
    end else if (mem_addr !== exp_addr) begin
      errors++;
      $display("FAIL scrub_read addr: got %0d, expected %0d", mem_addr, exp_addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 4'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({host_gnt, mem_en, mem_we, host_rvalid, host_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset strobes: got gnt/en/we/rvalid/err=%b, expected 00000",
               {host_gnt, mem_en, mem_we, host_rvalid, host_err});
    end
    checks++;
    if ({corr_cnt, uncorr_cnt, err_addr, host_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset values: got corr=%0d uncorr=%0d err_addr=%0d rdata=%h, expected all 0",
               corr_cnt, uncorr_cnt, err_addr, host_rdata);
    end
    checks++;
    if ({corr_cnt_b, mem_en_b} !== 3'b0) begin
      errors++;
      $display("FAIL reset small: got corr=%0d en=%b, expected 0", corr_cnt_b, mem_en_b);
    end
    @(posedge clk);
    #1;
    host_req = 1'b0;
    rst_n    = 1'b1;
    idle(2);
  endtask

  task automatic test_host_rw();
    host_write(4'd3, 8'hA5);
    host_read(4'd3, 8'hA5, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_scrub_correct();
    bit got;
    mem_a[5] = ref_encode(8'h3C) ^ (13'd1 << 5);
    wr_q.push_back({4'd5, ref_encode(8'h3C)});
    scrub_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1500 && !got; i++) begin
      @(negedge clk);
      if (corr_cnt === 16'd1) got = 1'b1;
    end
    @(posedge clk);
    #1;
    scrub_en = 1'b0;
    idle(4);
    checks++;
    if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL scrub_correct counters: got corr=%0d uncorr=%0d, expected 1 0",
               corr_cnt, uncorr_cnt);
    end
    host_read(4'd5, 8'h3C, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic test_scrub_uncorr();
    bit got;
    mem_a[5] = ref_encode(8'h3C) ^ (13'd1 << 3) ^ (13'd1 << 6);
    scrub_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2500 && !got; i++) begin
      @(negedge clk);
      if (uncorr_cnt === 16'd1) got = 1'b1;
    end
    @(posedge clk);
    #1;
    scrub_en = 1'b0;
    idle(4);
    checks++;
    if (uncorr_cnt !== 16'd1 || err_addr !== 4'd5 || corr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL scrub_uncorr: got uncorr=%0d err_addr=%0d corr=%0d, expected 1 5 1",
               uncorr_cnt, err_addr, corr_cnt);
    end
    host_read(4'd5, 8'h00, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (uncorr_cnt !== 16'd2 || err_addr !== 4'd5) begin
      errors++;
      $display("FAIL host_uncorr: got uncorr=%0d err_addr=%0d, expected 2 5", uncorr_cnt, err_addr);
    end
    mem_a[5] = ref_encode(8'h3C);
  endtask

  task automatic test_host_during_scrub();
    int t;
    int g;
    mem_a[6] = ref_encode(8'h5A) ^ (13'd1 << 9);
    wr_q.push_back({4'd6, ref_encode(8'h5A)});
    wr_q.push_back({4'd7, ref_encode(8'h11)});
    scrub_en = 1'b1;
    find_scrub_read(4'd6, t);
    @(posedge clk);
    #1;
    scrub_en = 1'b0;
    @(posedge clk);
    #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h11;
    wait_gnt(g);
    checks++;
    if (g != t + 4) begin
      errors++;
      $display("FAIL gnt_after_wb: got grant cycle %0d, expected %0d", g, t + 4);
    end
    idle(2);
    checks++;
    if (corr_cnt !== 16'd2) begin
      errors++;
      $display("FAIL host_during_scrub corr: got %0d, expected 2", corr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    mem_a[9]  = ref_encode(8'h96) ^ 13'd1;
    mem_a[10] = ref_encode(8'h42) ^ (13'd1 << 12);
    host_read(4'd6, 8'h5A, 1'b0, 1'b1);
    host_read(4'd7, 8'h11, 1'b0, 1'b1);
    host_write(4'd8, 8'hFF);
    host_read(4'd8, 8'hFF, 1'b0, 1'b1);
    host_read(4'd3, 8'hA5, 1'b0, 1'b1);
    host_read(4'd9, 8'h96, 1'b0, 1'b1);
    host_read(4'd10, 8'h42, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (uncorr_cnt !== 16'd2 || corr_cnt !== 16'd2) begin
      errors++;
      $display("FAIL back_to_back counters: got corr=%0d uncorr=%0d, expected 2 2",
               corr_cnt, uncorr_cnt);
    end
  endtask

  task automatic test_small_wrap();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [7:0] d [4];
    int nrd;
    int nwr;
    for (int i = 0; i < 4; i++) begin
      d[i]     = 8'(8'h21 * (i + 1));
      mem_b[i] = ref_encode(d[i]) ^ (13'd1 << (3 * i + 1));
    end
    nrd = 0;
    nwr = 0;
    scrub_en_b = 1'b1;
    for (int i = 0; i < 100 && nrd < 5; i++) begin
      @(negedge clk);
      if (mem_en_b === 1'b1 && mem_we_b === 1'b0) begin
        checks++;
        if (int'(mem_addr_b) != exp_seq[nrd]) begin
          errors++;
          $display("FAIL small_ptr[%0d]: got %0d, expected %0d", nrd, mem_addr_b, exp_seq[nrd]);
        end
        nrd++;
      end
      if (mem_en_b === 1'b1 && mem_we_b === 1'b1 && nwr < 4) begin
        checks++;
        if (int'(mem_addr_b) != nwr || mem_wdata_b !== ref_encode(d[nwr])) begin
          errors++;
          $display("FAIL small_wb[%0d]: got addr=%0d wdata=%h, expected addr=%0d wdata=%h",
                   nwr, mem_addr_b, mem_wdata_b, nwr, ref_encode(d[nwr]));
        end
        nwr++;
      end
    end
    @(posedge clk);
    #1;
    scrub_en_b = 1'b0;
    idle(5);
    checks++;
    if (nrd != 5 || nwr != 4 || corr_cnt_b !== 2'd3 || uncorr_cnt_b !== 2'd0) begin
      errors++;
      $display("FAIL small_summary: got reads=%0d wbs=%0d corr=%0d uncorr=%0d, expected 5 4 3 0",
               nrd, nwr, corr_cnt_b, uncorr_cnt_b);
    end
  endtask

  task automatic test_reset_during_wb();
    int t;
    mem_a[7] = ref_encode(8'h11) ^ (13'd1 << 7);
    scrub_en = 1'b1;
    find_scrub_read(4'd7, t);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || cyc != t + 3) begin
      errors++;
      $display("FAIL reset_wb strobes: got en=%b we=%b cycle=%0d, expected 0 0 %0d",
               mem_en, mem_we, cyc, t + 3);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({corr_cnt, uncorr_cnt, err_addr, host_rdata, host_rvalid, host_err} !== '0) begin
      errors++;
      $display("FAIL reset_wb outputs: got corr=%0d uncorr=%0d err_addr=%0d rdata=%h, expected 0",
               corr_cnt, uncorr_cnt, err_addr, host_rdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    find_scrub_read(4'd0, t);
    @(posedge clk);
    #1;
    scrub_en = 1'b0;
    idle(5);
  endtask

  initial begin
    rst_n = 1'b0; scrub_en = 1'b0; scrub_en_b = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 16; i++) mem_a[i] = '0;
    for (int i = 0; i < 4; i++) mem_b[i] = '0;
    test_reset();
    test_host_rw();
    test_scrub_correct();
    test_scrub_uncorr();
    test_host_during_scrub();
    test_back_to_back();
    test_small_wrap();
    test_reset_during_wb();
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes %0d reads outstanding, expected 0 0",
               wr_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
